// File: rtl/phase_cycler_if.sv
// phase_cycler_if: control and status bundle for phase_cycler.
// phase_onehot exists only when CYCLER_ONEHOT_EN is defined.
interface phase_cycler_if #(
`ifdef CYCLER_ONEHOT_EN
  parameter int NUM_PHASES = 3,
`endif
  parameter int PHASE_W = 2,
  parameter int DWELL_W = 8
);

  logic               enable;
  logic               dir;
  logic [DWELL_W-1:0] dwell;
  logic               load;
  logic [PHASE_W-1:0] load_phase;

  logic [PHASE_W-1:0] cycle_out;
  logic               phase_tick;
  logic               wrap;
  logic               load_err;
`ifdef CYCLER_ONEHOT_EN
  logic [NUM_PHASES-1:0] phase_onehot;
`endif

  modport master (
    output enable,
    output dir,
    output dwell,
    output load,
    output load_phase,
    input  cycle_out,
    input  phase_tick,
    input  wrap,
`ifdef CYCLER_ONEHOT_EN
    input  phase_onehot,
`endif
    input  load_err
  );

  modport slave (
    input  enable,
    input  dir,
    input  dwell,
    input  load,
    input  load_phase,
    output cycle_out,
    output phase_tick,
    output wrap,
`ifdef CYCLER_ONEHOT_EN
    output phase_onehot,
`endif
    output load_err
  );

endinterface

// File: rtl/phase_cycler.sv
// phase_cycler: up/down phase sequencer with per-phase dwell and load.
// Optional one-hot phase decode is built when CYCLER_ONEHOT_EN is defined.
module phase_cycler #(
  parameter int NUM_PHASES = 3,
  parameter int PHASE_W    = 2,
  parameter int DWELL_W    = 8
) (
  input logic           clk,
  input logic           reset,
  phase_cycler_if.slave bus
);

  localparam logic [PHASE_W-1:0] LAST =
    PHASE_W'(NUM_PHASES - 1);
  localparam logic [PHASE_W:0] NP_EXT =
    (PHASE_W+1)'(NUM_PHASES);

  logic [PHASE_W-1:0] ph;
  logic [PHASE_W-1:0] ph_nxt;
  logic [PHASE_W-1:0] ph_up;
  logic [PHASE_W-1:0] ph_dn;
  logic [DWELL_W-1:0] dc;
  logic [DWELL_W-1:0] dc_nxt;
  logic               tick;
  logic               tick_nxt;
  logic               wrap;
  logic               wrap_nxt;
  logic               err;
  logic               err_nxt;
  logic               load_ok;
  logic               run;
  logic               adv;

  // Loads outside the phase range are rejected, never truncated.
  assign load_ok = {1'b0, bus.load_phase} < NP_EXT;

  // Dwell is compared live with >= so a lowered dwell advances at once.
  assign run = !bus.load && bus.enable;
  assign adv = run && (dc >= bus.dwell);

  // Neighbouring phases with wrap at both ends of the range.
  assign ph_up = (ph == LAST) ? '0 : ph + 1'b1;
  assign ph_dn = (ph == '0) ? LAST : ph - 1'b1;

  // Next-state select: load beats enable, enable beats hold.
  always_comb begin
    ph_nxt   = ph;
    dc_nxt   = dc;
    tick_nxt = 1'b0;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    unique case (1'b1)
      bus.load && load_ok: begin
        ph_nxt = bus.load_phase;
        dc_nxt = '0;
      end
      bus.load && !load_ok: begin
        err_nxt = 1'b1;
      end
      adv: begin
        dc_nxt   = '0;
        tick_nxt = 1'b1;
        if (bus.dir) begin
          ph_nxt   = ph_dn;
          wrap_nxt = (ph == '0);
        end else begin
          ph_nxt   = ph_up;
          wrap_nxt = (ph == LAST);
        end
      end
      run && !adv: begin
        dc_nxt = dc + 1'b1;
      end
      default: ;
    endcase
  end

  // Phase, dwell counter and strobes, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph   <= '0;
      dc   <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      ph   <= ph_nxt;
      dc   <= dc_nxt;
      tick <= tick_nxt;
      wrap <= wrap_nxt;
      err  <= err_nxt;
    end
  end

  assign bus.cycle_out  = ph;
  assign bus.phase_tick = tick;
  assign bus.wrap       = wrap;
  assign bus.load_err   = err;

`ifdef CYCLER_ONEHOT_EN
  // One-hot decode of the registered phase; only comb output path.
  always_comb begin
    bus.phase_onehot = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (ph == PHASE_W'(i)) begin
        bus.phase_onehot[i] = 1'b1;
      end
    end
  end
`endif

endmodule
